// File: rtl/pipe_decode.sv
// Decode stage of a small 64-bit ARM-like pipeline: opcode classification, register file
// with writeback bypass, immediate generation, load-use hazard stall and a 1-deep output register.
module pipe_decode #(
   parameter int DATA_W  = 64,
   parameter int REG_CNT = 32,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instr,
   input  logic [DATA_W-1:0] pc_in,
   input  logic              wb_en,
   input  logic [4:0]        wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              ex_memread,
   input  logic [4:0]        ex_rd,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_pc,
   output logic [DATA_W-1:0] out_rd1,
   output logic [DATA_W-1:0] out_rd2,
   output logic [DATA_W-1:0] out_imm,
   output logic [4:0]        out_rd,
   output logic [2:0]        out_class,
   output logic [CNT_W-1:0]  stall_cnt
);
   localparam logic [4:0] XZR     = 5'(REG_CNT - 1);
   localparam logic [2:0] CLS_R   = 3'd0;
   localparam logic [2:0] CLS_I   = 3'd1;
   localparam logic [2:0] CLS_LD  = 3'd2;
   localparam logic [2:0] CLS_ST  = 3'd3;
   localparam logic [2:0] CLS_B   = 3'd4;
   localparam logic [2:0] CLS_CB  = 3'd5;
   localparam logic [2:0] CLS_INV = 3'd7;

   // Handshake: a transfer happens on a rising edge where valid and ready are both high;
   // valid never waits on ready, and a presented output holds stable until it transfers.
   logic [DATA_W-1:0] rf_q [REG_CNT];
   logic [DATA_W-1:0] rf_d [REG_CNT];
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_pc_q, out_pc_d, out_rd1_q, out_rd1_d;
   logic [DATA_W-1:0] out_rd2_q, out_rd2_d, out_imm_q, out_imm_d;
   logic [4:0]        out_rd_q, out_rd_d;
   logic [2:0]        out_class_q, out_class_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   logic [2:0]        cls;
   logic [4:0]        rn, ra2, dec_rd;
   logic [DATA_W-1:0] imm, rd1_val, rd2_val;
   logic              use1, use2, hazard, advance, accept;

   always_comb begin
      cls = CLS_INV;
      if (instr[31:21] == 11'b10001011000 || instr[31:21] == 11'b11001011000 ||
          instr[31:21] == 11'b10001010000 || instr[31:21] == 11'b10101010000)
         cls = CLS_R;
      else if (instr[31:22] == 10'b1001000100) cls = CLS_I;
      else if (instr[31:21] == 11'b11111000010) cls = CLS_LD;
      else if (instr[31:21] == 11'b11111000000) cls = CLS_ST;
      else if (instr[31:26] == 6'b000101) cls = CLS_B;
      else if (instr[31:24] == 8'b10110100) cls = CLS_CB;
   end

   assign rn     = instr[9:5];
   assign ra2    = (cls == CLS_R) ? instr[20:16] : instr[4:0];
   assign dec_rd = (cls == CLS_R || cls == CLS_I || cls == CLS_LD) ? instr[4:0] : 5'd31;

   always_comb begin
      imm = '0;
      case (cls)
         CLS_I:          imm = {{(DATA_W-12){1'b0}}, instr[21:10]};
         CLS_LD, CLS_ST: imm = {{(DATA_W-9){instr[20]}}, instr[20:12]};
         CLS_B:          imm = {{(DATA_W-26){instr[25]}}, instr[25:0]};
         CLS_CB:         imm = {{(DATA_W-19){instr[23]}}, instr[23:5]};
         default:        imm = '0;
      endcase
   end

   // XZR reads as zero and is never bypassed, even when writeback targets it.
   always_comb begin
      if (rn >= XZR) rd1_val = '0;
      else if (wb_en && wb_addr == rn) rd1_val = wb_data;
      else rd1_val = rf_q[rn];
      if (ra2 >= XZR) rd2_val = '0;
      else if (wb_en && wb_addr == ra2) rd2_val = wb_data;
      else rd2_val = rf_q[ra2];
   end

   always_comb begin
      use1 = 1'b0;
      use2 = 1'b0;
      case (cls)
         CLS_R, CLS_ST: begin use1 = 1'b1; use2 = 1'b1; end
         CLS_I, CLS_LD: use1 = 1'b1;
         CLS_CB:        use2 = 1'b1;
         default:       ;
      endcase
   end

   assign hazard   = ex_memread && (ex_rd != XZR) && in_valid &&
                     ((use1 && ex_rd == rn) || (use2 && ex_rd == ra2));
   assign advance  = !out_valid_q || out_ready;
   assign in_ready = rst_n && advance && !hazard && !flush;
   assign accept   = in_valid && in_ready;

   always_comb begin
      rf_d = rf_q;
      if (wb_en && wb_addr < XZR) rf_d[wb_addr] = wb_data;
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_pc_d    = out_pc_q;
      out_rd1_d   = out_rd1_q;
      out_rd2_d   = out_rd2_q;
      out_imm_d   = out_imm_q;
      out_rd_d    = out_rd_q;
      out_class_d = out_class_q;
      stall_cnt_d = stall_cnt_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d = 1'b1;
         out_pc_d    = pc_in;
         out_rd1_d   = rd1_val;
         out_rd2_d   = rd2_val;
         out_imm_d   = imm;
         out_rd_d    = dec_rd;
         out_class_d = cls;
      end else if (advance) begin
         out_valid_d = 1'b0;
      end
      if (hazard && !flush && stall_cnt_q != '1)
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_CNT; i++) rf_q[i] <= '0;
         out_valid_q <= 1'b0;
         out_pc_q    <= '0;
         out_rd1_q   <= '0;
         out_rd2_q   <= '0;
         out_imm_q   <= '0;
         out_rd_q    <= 5'd31;
         out_class_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         rf_q        <= rf_d;
         out_valid_q <= out_valid_d;
         out_pc_q    <= out_pc_d;
         out_rd1_q   <= out_rd1_d;
         out_rd2_q   <= out_rd2_d;
         out_imm_q   <= out_imm_d;
         out_rd_q    <= out_rd_d;
         out_class_q <= out_class_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_pc    = out_pc_q;
   assign out_rd1   = out_rd1_q;
   assign out_rd2   = out_rd2_q;
   assign out_imm   = out_imm_q;
   assign out_rd    = out_rd_q;
   assign out_class = out_class_q;
   assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipe_decode.sv
// Directed bench for pipe_decode: writeback/decode, bypass, load-use stall, backpressure,
// flush, XZR, immediates and reset, with hand-computed expected values.
module tb_pipe_decode;
   localparam logic [31:0] ADD_3_1_2 = 32'h8B020023;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0, in_ready;
   logic [31:0] instr = '0;
   logic [63:0] pc_in = '0;
   logic        wb_en = 1'b0;
   logic [4:0]  wb_addr = '0;
   logic [63:0] wb_data = '0;
   logic        ex_memread = 1'b0;
   logic [4:0]  ex_rd = '0;
   logic        flush = 1'b0;
   logic        out_valid, out_ready = 1'b1;
   logic [63:0] out_pc, out_rd1, out_rd2, out_imm;
   logic [4:0]  out_rd;
   logic [2:0]  out_class;
   logic [15:0] stall_cnt;
   int          n_vec = 0;
   int          n_err = 0;

   pipe_decode dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .pc_in(pc_in), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .ex_memread(ex_memread), .ex_rd(ex_rd), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rd1(out_rd1),
      .out_rd2(out_rd2), .out_imm(out_imm), .out_rd(out_rd), .out_class(out_class),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      in_valid = 1'b1; instr = ADD_3_1_2;
      #1;
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      n_vec++; if (out_rd !== 5'd31) begin n_err++; $display("FAIL rst_out_rd: got %0d want 31", out_rd); end
      n_vec++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL rst_stall: got %0d want 0", stall_cnt); end
      n_vec++; if (out_imm !== 64'd0 || out_class !== 3'd0) begin n_err++; $display("FAIL rst_imm_class: got %h/%0d want 0/0", out_imm, out_class); end
      step(); step();
      in_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n_vec++; if (out_valid !== 1'b1 || out_rd1 !== 64'd0 || out_rd2 !== 64'd0) begin n_err++; $display("FAIL rst_rf_zero: got v=%b %h %h want 1 0 0", out_valid, out_rd1, out_rd2); end
   endtask

   task automatic test_wb_decode();
      wb_en = 1'b1; wb_addr = 5'd1; wb_data = 64'd5;
      step();
      wb_addr = 5'd2; wb_data = 64'd7;
      step();
      wb_en = 1'b0; in_valid = 1'b1; instr = ADD_3_1_2; pc_in = 64'h100;
      #1;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL wb_in_ready: got %b want 1", in_ready); end
      step();
      in_valid = 1'b0;
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL wb_valid: got %b want 1", out_valid); end
      n_vec++; if (out_rd1 !== 64'd5) begin n_err++; $display("FAIL wb_rd1: got %h want 5", out_rd1); end
      n_vec++; if (out_rd2 !== 64'd7) begin n_err++; $display("FAIL wb_rd2: got %h want 7", out_rd2); end
      n_vec++; if (out_rd !== 5'd3 || out_class !== 3'd0) begin n_err++; $display("FAIL wb_rd_class: got %0d/%0d want 3/0", out_rd, out_class); end
      n_vec++; if (out_pc !== 64'h100) begin n_err++; $display("FAIL wb_pc: got %h want 100", out_pc); end
      step();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL wb_bubble: got %b want 0", out_valid); end
   endtask

   task automatic test_bypass();
      wb_en = 1'b1; wb_addr = 5'd1; wb_data = 64'h55;
      in_valid = 1'b1; instr = ADD_3_1_2; pc_in = 64'h104;
      step();
      wb_en = 1'b0; in_valid = 1'b0;
      n_vec++; if (out_rd1 !== 64'h55) begin n_err++; $display("FAIL byp_rd1: got %h want 55", out_rd1); end
      n_vec++; if (out_rd2 !== 64'd7 || out_valid !== 1'b1) begin n_err++; $display("FAIL byp_rd2: got %h v=%b want 7 v=1", out_rd2, out_valid); end
   endtask

   task automatic test_load_use();
      ex_memread = 1'b1; ex_rd = 5'd1;
      in_valid = 1'b1; instr = ADD_3_1_2; pc_in = 64'h108;
      #1;
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL lu_ready_low: got %b want 0", in_ready); end
      step();
      ex_memread = 1'b0;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lu_bubble: got %b want 0", out_valid); end
      n_vec++; if (stall_cnt !== 16'd1) begin n_err++; $display("FAIL lu_stall: got %0d want 1", stall_cnt); end
      #1;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL lu_ready_high: got %b want 1", in_ready); end
      step();
      in_valid = 1'b0;
      n_vec++; if (out_valid !== 1'b1 || out_pc !== 64'h108 || out_rd1 !== 64'h55) begin n_err++; $display("FAIL lu_issue: got v=%b pc=%h rd1=%h want 1 108 55", out_valid, out_pc, out_rd1); end
      n_vec++; if (stall_cnt !== 16'd1) begin n_err++; $display("FAIL lu_stall_hold: got %0d want 1", stall_cnt); end
   endtask

   task automatic test_hazard_classes();
      ex_memread = 1'b1; ex_rd = 5'd2; in_valid = 1'b1; instr = ADD_3_1_2;
      #1;
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hz_rm: got %b want 0", in_ready); end
      step();
      ex_rd = 5'd1; instr = 32'h14000001;
      #1;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL hz_b_none: got %b want 1", in_ready); end
      step();
      n_vec++; if (out_class !== 3'd4 || out_imm !== 64'd1) begin n_err++; $display("FAIL hz_b_out: got %0d/%h want 4/1", out_class, out_imm); end
      instr = 32'hB4000001;
      #1;
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hz_cb_rt: got %b want 0", in_ready); end
      step();
      ex_rd = 5'd31; instr = 32'h8B1F03E3;
      #1;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL hz_xzr: got %b want 1", in_ready); end
      step();
      ex_memread = 1'b0; in_valid = 1'b0;
      n_vec++; if (out_rd1 !== 64'd0 || out_rd !== 5'd3) begin n_err++; $display("FAIL hz_xzr_out: got %h/%0d want 0/3", out_rd1, out_rd); end
      n_vec++; if (stall_cnt !== 16'd3) begin n_err++; $display("FAIL hz_stall: got %0d want 3", stall_cnt); end
   endtask

   task automatic test_backpressure();
      in_valid = 1'b1; instr = 32'h91048C25; pc_in = 64'h200;
      step();
      n_vec++; if (out_class !== 3'd1 || out_imm !== 64'h123 || out_rd !== 5'd5 || out_rd1 !== 64'h55) begin n_err++; $display("FAIL bp_addi: got %0d %h %0d %h want 1 123 5 55", out_class, out_imm, out_rd, out_rd1); end
      out_ready = 1'b0; instr = ADD_3_1_2; pc_in = 64'h204;
      #1;
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_low: got %b want 0", in_ready); end
      for (int i = 0; i < 3; i++) begin
         step();
         n_vec++; if (out_valid !== 1'b1 || out_class !== 3'd1 || out_imm !== 64'h123 || out_pc !== 64'h200 || out_rd !== 5'd5 || in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold%0d: got v=%b c=%0d imm=%h pc=%h rd=%0d rdy=%b want 1 1 123 200 5 0", i, out_valid, out_class, out_imm, out_pc, out_rd, in_ready); end
      end
      out_ready = 1'b1;
      #1;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_high: got %b want 1", in_ready); end
      step();
      in_valid = 1'b0;
      n_vec++; if (out_pc !== 64'h204 || out_class !== 3'd0 || out_rd !== 5'd3) begin n_err++; $display("FAIL bp_release: got pc=%h c=%0d rd=%0d want 204 0 3", out_pc, out_class, out_rd); end
   endtask

   task automatic test_flush_xzr();
      out_ready = 1'b0; flush = 1'b1;
      wb_en = 1'b1; wb_addr = 5'd4; wb_data = 64'h99;
      in_valid = 1'b1; instr = ADD_3_1_2; pc_in = 64'h300;
      ex_memread = 1'b1; ex_rd = 5'd1;
      #1;
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fl_ready: got %b want 0", in_ready); end
      step();
      flush = 1'b0; wb_en = 1'b0; ex_memread = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fl_valid: got %b want 0", out_valid); end
      n_vec++; if (stall_cnt !== 16'd3) begin n_err++; $display("FAIL fl_stall: got %0d want 3", stall_cnt); end
      in_valid = 1'b1; instr = 32'h8B0403E7; pc_in = 64'h304;
      wb_en = 1'b1; wb_addr = 5'd31; wb_data = 64'hFF;
      step();
      wb_en = 1'b0; pc_in = 64'h308;
      n_vec++; if (out_rd1 !== 64'd0 || out_rd2 !== 64'h99 || out_rd !== 5'd7) begin n_err++; $display("FAIL fl_wb_xzr_same: got %h %h %0d want 0 99 7", out_rd1, out_rd2, out_rd); end
      step();
      in_valid = 1'b0;
      n_vec++; if (out_rd1 !== 64'd0 || out_pc !== 64'h308) begin n_err++; $display("FAIL xzr_later: got %h pc=%h want 0 308", out_rd1, out_pc); end
   endtask

   task automatic test_back_to_back_imm();
      logic [31:0] tv_instr [7];
      logic [2:0]  tv_cls [7];
      logic [63:0] tv_imm [7];
      logic [4:0]  tv_rd [7];
      tv_instr[0] = 32'hF85F8024; tv_cls[0] = 3'd2; tv_imm[0] = 64'hFFFF_FFFF_FFFF_FFF8; tv_rd[0] = 5'd4;
      tv_instr[1] = 32'hB4FFFFE2; tv_cls[1] = 3'd5; tv_imm[1] = 64'hFFFF_FFFF_FFFF_FFFF; tv_rd[1] = 5'd31;
      tv_instr[2] = 32'hF8010022; tv_cls[2] = 3'd3; tv_imm[2] = 64'h10;                  tv_rd[2] = 5'd31;
      tv_instr[3] = 32'h16000000; tv_cls[3] = 3'd4; tv_imm[3] = 64'hFFFF_FFFF_FE00_0000; tv_rd[3] = 5'd31;
      tv_instr[4] = 32'hAA020029; tv_cls[4] = 3'd0; tv_imm[4] = 64'd0;                   tv_rd[4] = 5'd9;
      tv_instr[5] = 32'h913FFC00; tv_cls[5] = 3'd1; tv_imm[5] = 64'hFFF;                 tv_rd[5] = 5'd0;
      tv_instr[6] = 32'h00000000; tv_cls[6] = 3'd7; tv_imm[6] = 64'd0;                   tv_rd[6] = 5'd31;
      in_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         instr = tv_instr[i]; pc_in = 64'h400 + 64'(4 * i);
         step();
         n_vec++; if (out_valid !== 1'b1 || out_class !== tv_cls[i] || out_imm !== tv_imm[i] || out_rd !== tv_rd[i] || out_pc !== 64'h400 + 64'(4 * i)) begin n_err++; $display("FAIL imm%0d: got v=%b c=%0d imm=%h rd=%0d pc=%h want 1 %0d %h %0d", i, out_valid, out_class, out_imm, out_rd, out_pc, tv_cls[i], tv_imm[i], tv_rd[i]); end
         if (i == 0) begin
            n_vec++; if (out_rd2 !== 64'h99) begin n_err++; $display("FAIL ldur_rt: got %h want 99", out_rd2); end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      in_valid = 1'b1; instr = ADD_3_1_2; pc_in = 64'h500;
      step();
      #2 rst_n = 1'b0;
      #1;
      n_vec++; if (out_valid !== 1'b0 || out_rd !== 5'd31 || out_pc !== 64'd0 || in_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst: got v=%b rd=%0d pc=%h rdy=%b want 0 31 0 0", out_valid, out_rd, out_pc, in_ready); end
      n_vec++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL mid_rst_stall: got %0d want 0", stall_cnt); end
      step();
      rst_n = 1'b1;
      step();
      n_vec++; if (out_rd1 !== 64'd0 || out_rd2 !== 64'd0 || out_valid !== 1'b1) begin n_err++; $display("FAIL mid_rst_rf: got %h %h v=%b want 0 0 1", out_rd1, out_rd2, out_valid); end
      in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_wb_decode();
      test_bypass();
      test_load_use();
      test_hazard_classes();
      test_backpressure();
      test_flush_xzr();
      test_back_to_back_imm();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/pipe_decode.md
PIPE_DECODE -- requirements
Module: pipe_decode

Interface
REQ-001 SHALL have parameter DATA_W, default 64: datapath and register width.
REQ-002 SHALL have parameter REG_CNT, default 32: architectural registers; index REG_CNT-1 is XZR.
REQ-003 SHALL have parameter CNT_W, default 16: width of the stall counter.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1): fetch-side handshake.
REQ-007 SHALL have ports instr (input, 32) and pc_in (input, DATA_W): instruction and PC from fetch.
REQ-008 SHALL have ports wb_en (input, 1), wb_addr (input, 5) and wb_data (input, DATA_W): writeback port.
REQ-009 SHALL have ports ex_memread (input, 1) and ex_rd (input, 5): execute-stage load destination for hazard detection.
REQ-010 SHALL have port flush (input, 1): branch-taken squash.
REQ-011 SHALL have ports out_valid (output, 1) and out_ready (input, 1): execute-side handshake.
REQ-012 SHALL have outputs out_pc (DATA_W), out_rd1 (DATA_W), out_rd2 (DATA_W), out_imm (DATA_W), out_rd (5) and out_class (3), all registered.
REQ-013 SHALL have output stall_cnt (CNT_W): count of hazard-stall cycles.

Function
REQ-014 SHALL decode opcodes as follows.
- ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 (instr[31:21]) -> class 0 (R).
- ADDI 1001000100 (instr[31:22]) -> class 1 (I).
- LDUR 11111000010 -> class 2; STUR 11111000000 -> class 3 (D).
- B 000101 (instr[31:26]) -> class 4.
- CBZ 10110100 (instr[31:24]) -> class 5.
- Anything else -> class 7 (invalid); it passes through with out_imm=0.
REQ-015 SHALL take read port 1 from Rn=instr[9:5]; read port 2 from Rm=instr[20:16] for class 0, else Rt=instr[4:0] (Reg2Loc).
REQ-016 SHALL form the immediate per class.
- I: zero-extend instr[21:10].
- D: sign-extend instr[20:12].
- B: sign-extend instr[25:0].
- CB: sign-extend instr[23:5].
- R: 0.
REQ-017 SHALL set out_rd=instr[4:0] for classes 0, 1, 2 and out_rd=31 otherwise.
REQ-018 SHALL implement the register file as REG_CNT x DATA_W.
- Writes are synchronous when wb_en=1.
- Writes to index 31 are ignored.
- Reads of index 31 return 0.
REQ-019 SHALL bypass writeback to reads: if wb_en=1 and wb_addr equals a nonzero-XZR read index in the same cycle, the read returns wb_data.
REQ-020 SHALL assert hazard when all of the following hold: ex_memread=1, ex_rd!=31, in_valid=1, and ex_rd equals a source register the class uses.
- R and D-store use Rn and read port 2.
- I and LDUR use Rn.
- CB uses Rt.
- B uses none.
REQ-021 SHALL drive in_ready = (!out_valid | out_ready) & !hazard & !flush, combinationally.
REQ-022 SHALL capture the decoded instruction into the output registers with out_valid=1 in the cycle after in_valid & in_ready.
REQ-023 SHALL load a bubble (out_valid=0) when the output can advance (!out_valid | out_ready) but no input is accepted.
REQ-024 SHALL hold the output registers unchanged while out_valid=1 and out_ready=0; stability under backpressure is mandatory.
REQ-025 SHALL clear out_valid on the edge after flush=1, independent of out_ready; the instruction presented that cycle is dropped.
REQ-026 SHALL still perform the writeback in the same cycle as a flush.
REQ-027 SHALL increment stall_cnt by 1 each cycle hazard=1, saturating at all-ones; flush cycles do not count.
REQ-028 SHALL keep latency at exactly 1 cycle from acceptance to out_valid; throughput is one instruction per cycle absent hazards or backpressure.

Reset
REQ-029 SHALL, while rst_n=0 (asynchronously), set all registers to 0.
- Registers: register file, out_valid, out_pc, out_rd1, out_rd2, out_imm, out_class, stall_cnt.
- out_rd resets to 31.
REQ-030 SHALL drive in_ready=0 while rst_n=0, and reassert it the first cycle after release.
REQ-031 SHALL, on reset mid-transfer, discard the in-flight instruction; no partial output is ever visible.

Verification
REQ-032 SHALL cover the writeback-then-decode case.
- Stimulus: write X1=5, X2=7, then ADD X3,X1,X2 (0x8B020023).
- Required: out_rd1=5, out_rd2=7, out_rd=3, out_class=0, one cycle after acceptance.
REQ-033 SHALL cover same-cycle bypass.
- Stimulus: wb_en=1, wb_addr=1, wb_data=0x55 in the same cycle as ADD X3,X1,X2 is accepted.
- Required: out_rd1=0x55.
REQ-034 SHALL cover load-use stall.
- Stimulus: ex_memread=1, ex_rd=1 with ADD X3,X1,X2 valid for 1 cycle.
- Required: in_ready=0, a bubble on the output, stall_cnt 0->1; the instruction issues the next cycle once ex_memread=0.
REQ-035 SHALL cover backpressure.
- Stimulus: out_ready=0 for 3 cycles with out_valid=1.
- Required: all out_* stable, in_ready=0; the transfer completes on the first out_ready=1 edge.
REQ-036 SHALL cover flush and XZR handling.
- Flush with out_valid=1, out_ready=0 -> out_valid=0 next cycle.
- Write to X31 of 0xFF -> a later read of X31 returns 0.
REQ-037 SHALL cover immediates.
- LDUR X4,[X1,#-8] (imm9=0x1F8) -> out_imm=0xFFFFFFFFFFFFFFF8, class 2.
- CBZ with imm19=0x7FFFF -> out_imm=all-ones.
